// File: rtl/pcie_host_responder.sv
// rtl/pcie_host_responder.sv - host-side responder for CNN PCIe request words; drives FM/kernel RAM writes and done flags
module pcie_host_responder #(
    parameter int ADDR_W       = 16,
    parameter int INIT_WORDS   = 256,
    parameter int KERNEL_WORDS = 75
) (
    input  logic              pcieConClk,
    input  logic              pcieConRst,
    input  logic [31:0]       reqSig_1,
    input  logic [31:0]       reqSig_2,
    input  logic [31:0]       reqSig_3,
    output logic [31:0]       respSig,
    input  logic [15:0]       kerData,
    input  logic              kerValid,
    output logic              kerReady,
    output logic              fmWe,
    output logic [ADDR_W-1:0] fmAddr,
    output logic [15:0]       fmData,
    output logic              kerWe,
    output logic              kerBank,
    output logic [ADDR_W-1:0] kerAddr,
    output logic [15:0]       kerWData
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FM_WR,
        FM_ACK,
        KER_LOAD,
        KER_ACK
    } state_t;

    localparam logic [ADDR_W:0] INIT_CNT = (ADDR_W+1)'(INIT_WORDS);
    localparam logic [ADDR_W:0] KER_LAST = (ADDR_W+1)'(KERNEL_WORDS - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    state_t            state, stateNext;
    logic [ADDR_W:0]   count, countNext;
    logic              initDone, initDoneNext;
    logic              respFm, respFmNext;
    logic              respKer, respKerNext;
    logic              busy, busyNext;
    logic              kerReadyNext;
    logic              fmWeNext;
    logic [ADDR_W-1:0] fmAddrNext;
    logic [15:0]       fmDataNext;
    logic              kerWeNext;
    logic              kerBankNext;
    logic [ADDR_W-1:0] kerAddrNext;
    logic [15:0]       kerWDataNext;

    // Only the documented request bits are decoded; the rest are don't-care.
    logic unusedReq;
    assign unusedReq = &{1'b0, reqSig_1, reqSig_2, reqSig_3};

    assign respSig = {28'd0, busy, respKer, respFm, initDone};

    always_ff @(posedge pcieConClk or posedge pcieConRst) begin
        if (pcieConRst) begin
            state    <= IDLE;
            count    <= '0;
            initDone <= 1'b0;
            respFm   <= 1'b0;
            respKer  <= 1'b0;
            busy     <= 1'b0;
            kerReady <= 1'b0;
            fmWe     <= 1'b0;
            fmAddr   <= '0;
            fmData   <= '0;
            kerWe    <= 1'b0;
            kerBank  <= 1'b0;
            kerAddr  <= '0;
            kerWData <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            initDone <= initDoneNext;
            respFm   <= respFmNext;
            respKer  <= respKerNext;
            busy     <= busyNext;
            kerReady <= kerReadyNext;
            fmWe     <= fmWeNext;
            fmAddr   <= fmAddrNext;
            fmData   <= fmDataNext;
            kerWe    <= kerWeNext;
            kerBank  <= kerBankNext;
            kerAddr  <= kerAddrNext;
            kerWData <= kerWDataNext;
        end
    end

    // Outputs are computed alongside the next state so every output lands in a register.
    always_comb begin
        stateNext    = state;
        countNext    = count;
        initDoneNext = initDone;
        respFmNext   = respFm;
        respKerNext  = respKer;
        kerReadyNext = 1'b0;
        fmWeNext     = 1'b0;
        fmAddrNext   = fmAddr;
        fmDataNext   = fmData;
        kerWeNext    = 1'b0;
        kerBankNext  = kerBank;
        kerAddrNext  = kerAddr;
        kerWDataNext = kerWData;

        case (state)
            IDLE: begin
                if (reqSig_1[0] && !initDone) begin
                    stateNext  = INIT;
                    fmWeNext   = 1'b1;
                    fmAddrNext = '0;
                    fmDataNext = '0;
                    countNext  = CNT_ONE;
                end else if (reqSig_1[1]) begin
                    stateNext  = FM_WR;
                    fmWeNext   = 1'b1;
                    fmAddrNext = reqSig_3[ADDR_W-1:0];
                    fmDataNext = reqSig_2[15:0];
                end else if (reqSig_1[2]) begin
                    stateNext    = KER_LOAD;
                    kerReadyNext = 1'b1;
                    kerBankNext  = reqSig_1[3];
                    countNext    = '0;
                end
            end
            INIT: begin
                // count holds the next address; the first word was issued on IDLE exit.
                if (count == INIT_CNT) begin
                    initDoneNext = 1'b1;
                    countNext    = '0;
                    stateNext    = IDLE;
                end else begin
                    fmWeNext   = 1'b1;
                    fmAddrNext = count[ADDR_W-1:0];
                    fmDataNext = '0;
                    countNext  = count + CNT_ONE;
                end
            end
            FM_WR: begin
                respFmNext = 1'b1;
                stateNext  = FM_ACK;
            end
            FM_ACK: begin
                if (!reqSig_1[1]) begin
                    respFmNext = 1'b0;
                    stateNext  = IDLE;
                end
            end
            KER_LOAD: begin
                kerReadyNext = 1'b1;
                if (kerValid && kerReady) begin
                    kerWeNext    = 1'b1;
                    kerAddrNext  = count[ADDR_W-1:0];
                    kerWDataNext = kerData;
                    countNext    = count + CNT_ONE;
                    if (count == KER_LAST) begin
                        kerReadyNext = 1'b0;
                        respKerNext  = 1'b1;
                        countNext    = '0;
                        stateNext    = KER_ACK;
                    end
                end
            end
            KER_ACK: begin
                if (!reqSig_1[2]) begin
                    respKerNext = 1'b0;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        busyNext = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_pcie_host_responder.sv
// tb/tb_pcie_host_responder.sv - scoreboard bench for pcie_host_responder
module tb_pcie_host_responder;

    localparam int ADDR_W = 16;

    logic              pcieConClk = 1'b0;
    logic              pcieConRst = 1'b1;
    logic [31:0]       reqSig_1 = '0;
    logic [31:0]       reqSig_2 = '0;
    logic [31:0]       reqSig_3 = '0;
    logic [31:0]       respSig;
    logic [15:0]       kerData = '0;
    logic              kerValid = 1'b0;
    logic              kerReady;
    logic              fmWe;
    logic [ADDR_W-1:0] fmAddr;
    logic [15:0]       fmData;
    logic              kerWe;
    logic              kerBank;
    logic [ADDR_W-1:0] kerAddr;
    logic [15:0]       kerWData;

    pcie_host_responder #(
        .ADDR_W      (ADDR_W),
        .INIT_WORDS  (4),
        .KERNEL_WORDS(3)
    ) dut (
        .pcieConClk(pcieConClk),
        .pcieConRst(pcieConRst),
        .reqSig_1  (reqSig_1),
        .reqSig_2  (reqSig_2),
        .reqSig_3  (reqSig_3),
        .respSig   (respSig),
        .kerData   (kerData),
        .kerValid  (kerValid),
        .kerReady  (kerReady),
        .fmWe      (fmWe),
        .fmAddr    (fmAddr),
        .fmData    (fmData),
        .kerWe     (kerWe),
        .kerBank   (kerBank),
        .kerAddr   (kerAddr),
        .kerWData  (kerWData)
    );

    always #5 pcieConClk = ~pcieConClk;

    typedef struct packed {
        logic        bank;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t fmQ[$];
    wr_t kerQ[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pcieConClk);
        #1;
    endtask

    function automatic wr_t mk(input logic bank, input logic [15:0] addr, input logic [15:0] data);
        wr_t w;
        w.bank = bank;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Monitor: every RAM write the DUT issues must match the head of its queue.
    always @(negedge pcieConClk) begin
        if (!pcieConRst) begin
            if (fmWe) begin
                if (fmQ.size() == 0) begin
                    chk("fm_unexpected_write", {16'd0, fmAddr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = fmQ.pop_front();
                    chk("fm_addr", {16'd0, fmAddr}, {16'd0, e.addr});
                    chk("fm_data", {16'd0, fmData}, {16'd0, e.data});
                end
            end
            if (kerWe) begin
                if (kerQ.size() == 0) begin
                    chk("ker_unexpected_write", {16'd0, kerAddr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = kerQ.pop_front();
                    chk("ker_bank", {31'd0, kerBank}, {31'd0, e.bank});
                    chk("ker_addr", {16'd0, kerAddr}, {16'd0, e.addr});
                    chk("ker_data", {16'd0, kerWData}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        int n;

        repeat (3) @(posedge pcieConClk);
        #1;
        chk("reset_resp", respSig, 32'h0);
        chk("reset_outs", {29'd0, kerReady, fmWe, kerWe}, 32'h0);
        pcieConRst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) fmQ.push_back(mk(1'b0, 16'(i), 16'h0));
        reqSig_1 = 32'h1;
        tick();
        chk("init_first_we", {31'd0, fmWe}, 32'h1);
        chk("init_busy", respSig, 32'h8);
        repeat (4) tick();
        chk("init_done_resp", respSig, 32'h1);
        chk("init_we_off", {31'd0, fmWe}, 32'h0);
        repeat (5) tick();
        chk("init_repeat_resp", respSig, 32'h1);
        reqSig_1 = 32'h0;
        tick();

        fmQ.push_back(mk(1'b0, 16'h0012, 16'hBEEF));
        reqSig_2 = 32'hFFFF_BEEF;
        reqSig_3 = 32'hABCD_0012;
        reqSig_1 = 32'h2;
        tick();
        chk("fm_we_cycle", {31'd0, fmWe}, 32'h1);
        tick();
        chk("fm_ack_resp", respSig, 32'hB);
        repeat (3) tick();
        chk("fm_ack_held", respSig, 32'hB);
        reqSig_1 = 32'h0;
        tick();
        chk("fm_ack_clear", respSig, 32'h1);

        fmQ.push_back(mk(1'b0, 16'h0034, 16'h1234));
        reqSig_2 = 32'h0000_1234;
        reqSig_3 = 32'h0000_0034;
        reqSig_1 = 32'h2;
        repeat (3) tick();
        reqSig_1 = 32'h0;
        tick();
        chk("fm2_clear", respSig, 32'h1);

        kerQ.push_back(mk(1'b1, 16'd0, 16'h000A));
        kerQ.push_back(mk(1'b1, 16'd1, 16'h000B));
        kerQ.push_back(mk(1'b1, 16'd2, 16'h000C));
        reqSig_1 = 32'hC;
        tick();
        chk("ker_ready_up", {31'd0, kerReady}, 32'h1);
        chk("ker_busy", respSig, 32'h9);
        kerValid = 1'b1; kerData = 16'h000A; tick();
        kerValid = 1'b0; kerData = 16'h0055; tick();
        kerValid = 1'b1; kerData = 16'h000B; tick();
        chk("ker_not_done", respSig, 32'h9);
        kerValid = 1'b1; kerData = 16'h000C; tick();
        kerValid = 1'b0;
        chk("ker_done_resp", respSig, 32'hD);
        chk("ker_ready_down", {31'd0, kerReady}, 32'h0);
        tick();
        chk("ker_ack_held", respSig, 32'hD);
        reqSig_1 = 32'h0;
        tick();
        chk("ker_ack_clear", respSig, 32'h1);

        kerQ.push_back(mk(1'b0, 16'd0, 16'h0055));
        reqSig_1 = 32'h4;
        tick();
        kerValid = 1'b1; kerData = 16'h0055; tick();
        kerValid = 1'b0;
        @(negedge pcieConClk);
        #1;
        pcieConRst = 1'b1;
        #1;
        chk("rst_mid_resp", respSig, 32'h0);
        chk("rst_mid_ctl", {28'd0, kerReady, kerWe, fmWe, kerBank}, 32'h0);
        chk("rst_mid_addr", {kerAddr, fmAddr}, 32'h0);
        chk("rst_mid_data", {kerWData, fmData}, 32'h0);
        reqSig_1 = 32'h0;
        tick();
        pcieConRst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) fmQ.push_back(mk(1'b0, 16'(i), 16'h0));
        fmQ.push_back(mk(1'b0, 16'h0077, 16'hCAFE));
        reqSig_2 = 32'h0000_CAFE;
        reqSig_3 = 32'h0000_0077;
        reqSig_1 = 32'h7;
        n = 0;
        while (!respSig[1] && n < 40) begin
            tick();
            n++;
        end
        chk("sim_fm_ack_seen", {31'd0, respSig[1]}, 32'h1);
        chk("sim_fm_resp", respSig, 32'hB);
        reqSig_1 = 32'h5;
        tick();
        chk("sim_idle_gap", respSig, 32'h1);
        for (int i = 0; i < 3; i++) kerQ.push_back(mk(1'b0, 16'(i), 16'(i + 1)));
        tick();
        chk("sim_ker_ready", {31'd0, kerReady}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            kerValid = 1'b1;
            kerData  = 16'(i + 1);
            tick();
        end
        kerValid = 1'b0;
        chk("sim_ker_done", respSig, 32'hD);
        reqSig_1 = 32'h0;
        tick();
        chk("sim_final_idle", respSig, 32'h1);
        repeat (2) tick();

        chk("fm_queue_empty", fmQ.size(), 32'h0);
        chk("ker_queue_empty", kerQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
